reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds downstream resets until PLL locks are stable, then releases domains in order.
// Optional hold-timeout detector enabled by RESET_SEQ_HOLD_TIMEOUT_EN.
module reset_sequencer #(
  parameter int NUM_LOCKS           = 2,
  parameter int NUM_DOMAINS         = 3,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int BTN_DEBOUNCE_CYCLES = 250000,
  parameter int STAGGER_CYCLES      = 16,
  parameter bit BTN_ACTIVE_LOW      = 1'b1
`ifdef RESET_SEQ_HOLD_TIMEOUT_EN
  ,parameter int HOLD_TIMEOUT_CYCLES = 2**24
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_LOCKS-1:0]   locked_i,
  input  logic                   btn_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
  output logic                   ready_o,
  output logic [1:0]             state_o,
  output logic                   lock_lost_o,
  output logic [7:0]             lock_loss_count_o
`ifdef RESET_SEQ_HOLD_TIMEOUT_EN
  ,output logic                  timeout_o
`endif
);
  localparam int REL_SPAN = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int CNT_MAX  = (LOCK_STABLE_CYCLES > REL_SPAN) ? LOCK_STABLE_CYCLES : REL_SPAN;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int DW       = $clog2(BTN_DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {HOLD, WAIT_STABLE, RELEASE, RUN} state_t;

  logic [1:0][NUM_LOCKS-1:0] lock_sync_q, lock_sync_d;
  logic [1:0]                btn_sync_q, btn_sync_d;
  logic [DW-1:0]             db_cnt_q, db_cnt_d;
  logic                      btn_db_q, btn_db_d;
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0]    dom_q, dom_d;
  logic                      ready_q, ready_d;
  logic                      lost_q, lost_d;
  logic [7:0]                loss_q, loss_d;
  logic                      all_locked, raw, fault;

  assign all_locked = &lock_sync_q[1];
  assign raw        = btn_sync_q[1] ^ BTN_ACTIVE_LOW;
  assign fault      = !all_locked | btn_db_q;

  always_comb begin
    lock_sync_d = {lock_sync_q[0], locked_i};
    btn_sync_d  = {btn_sync_q[0], btn_i};
    db_cnt_d    = '0;
    btn_db_d    = btn_db_q;
    if (raw != btn_db_q) begin
      if (db_cnt_q == DW'(BTN_DEBOUNCE_CYCLES - 1)) btn_db_d = raw;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    ready_d = ready_q;
    lost_d  = lost_q;
    loss_d  = loss_q;
    if (fault) begin
      state_d = HOLD;
      cnt_d   = '0;
      dom_d   = '0;
      ready_d = 1'b0;
      // lock loss wins over a simultaneous button press
      if (!all_locked && state_q != HOLD) begin
        lost_d = 1'b1;
        loss_d = loss_q + 8'(loss_q != 8'hff);
      end
    end else begin
      case (state_q)
        HOLD: begin
          state_d = WAIT_STABLE;
          cnt_d   = '0;
        end
        WAIT_STABLE: begin
          state_d = (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) ? RELEASE : WAIT_STABLE;
          cnt_d   = (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
        end
        RELEASE: begin
          cnt_d = cnt_q + 1'b1;
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (cnt_q == CW'(k * STAGGER_CYCLES)) begin
              dom_d[k] = 1'b1;
              if (k == NUM_DOMAINS - 1) begin
                state_d = RUN;
                ready_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RESET_SEQ_HOLD_TIMEOUT_EN
  localparam int TW = $clog2(HOLD_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;
  logic          hold_full;

  assign hold_full = hold_cnt_q == TW'(HOLD_TIMEOUT_CYCLES - 1);

  always_comb begin
    hold_cnt_d = (state_q != HOLD) ? '0 : hold_full ? hold_cnt_q : hold_cnt_q + 1'b1;
    timeout_d  = (state_d == RUN && state_q != RUN) ? 1'b0 :
                 (state_q == HOLD && hold_full) ? 1'b1 : timeout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
      db_cnt_q    <= '0;
      btn_db_q    <= 1'b0;
      state_q     <= HOLD;
      cnt_q       <= '0;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      lost_q      <= 1'b0;
      loss_q      <= '0;
    end else begin
      lock_sync_q <= lock_sync_d;
      btn_sync_q  <= btn_sync_d;
      db_cnt_q    <= db_cnt_d;
      btn_db_q    <= btn_db_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dom_q       <= dom_d;
      ready_q     <= ready_d;
      lost_q      <= lost_d;
      loss_q      <= loss_d;
    end
  end

  assign domain_rst_n_o    = dom_q;
  assign ready_o           = ready_q;
  assign state_o           = state_q;
  assign lock_lost_o       = lost_q;
  assign lock_loss_count_o = loss_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed test of power-up, lock loss, button, saturation and optional timeout.
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] locked;
  logic       btn;
  logic [2:0] dom;
  logic       ready;
  logic [1:0] state;
  logic       lost;
  logic [7:0] loss;
`ifdef RESET_SEQ_HOLD_TIMEOUT_EN
  logic       timeout;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  reset_sequencer #(
    .NUM_LOCKS(2), .NUM_DOMAINS(3), .LOCK_STABLE_CYCLES(8),
    .BTN_DEBOUNCE_CYCLES(4), .STAGGER_CYCLES(2), .BTN_ACTIVE_LOW(1'b1)
`ifdef RESET_SEQ_HOLD_TIMEOUT_EN
    ,.HOLD_TIMEOUT_CYCLES(32)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked_i(locked), .btn_i(btn),
    .domain_rst_n_o(dom), .ready_o(ready), .state_o(state),
    .lock_lost_o(lost), .lock_loss_count_o(loss)
`ifdef RESET_SEQ_HOLD_TIMEOUT_EN
    ,.timeout_o(timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; locked = 2'b11; btn = 1'b1;
    tick(3);
    check("rst_dom", dom, 3'b000);
    check("rst_state", state, 2'd0);
    check("rst_ready", ready, 1'b0);
    check("rst_lost", lost, 1'b0);
    check("rst_loss", loss, 8'd0);
    rst_n = 1'b1;
    tick(2);
    check("pu_hold", state, 2'd0);
    tick();
    check("pu_wait", state, 2'd1);
    tick(7);
    check("pu_wait_end", state, 2'd1);
    tick();
    check("pu_release", state, 2'd2);
    check("pu_dom_rel0", dom, 3'b000);
    tick();
    check("pu_dom1", dom, 3'b001);
    tick(2);
    check("pu_dom2", dom, 3'b011);
    tick();
    check("pu_ready_lo", ready, 1'b0);
    tick();
    check("pu_dom3", dom, 3'b111);
    check("pu_ready", ready, 1'b1);
    check("pu_run", state, 2'd3);

    locked = 2'b01;
    tick();
    locked = 2'b11;
    tick();
    check("drop_e2_dom", dom, 3'b111);
    tick();
    check("drop_e3_dom", dom, 3'b000);
    check("drop_state", state, 2'd0);
    check("drop_lost", lost, 1'b1);
    check("drop_loss", loss, 8'd1);
    wait_ready(lat);
    check("drop_relat", lat, 14);

    btn = 1'b0;
    tick(3);
    btn = 1'b1;
    tick(10);
    check("btn3_dom", dom, 3'b111);
    check("btn3_ready", ready, 1'b1);

    btn = 1'b0;
    tick(5);
    check("btn10_e5", dom, 3'b111);
    tick(2);
    check("btn10_e7", dom, 3'b000);
    check("btn10_state", state, 2'd0);
    tick(3);
    btn = 1'b1;
    tick(6);
    check("btnrel_e6", state, 2'd0);
    check("btnrel_dom", dom, 3'b000);
    tick();
    check("btnrel_e7", state, 2'd1);
    check("btn_loss", loss, 8'd1);
    wait_ready(lat);
    check("btn_relat", lat, 13);

    locked = 2'b10;
    tick();
    locked = 2'b11;
    tick(2);
    check("w_drop_loss", loss, 8'd2);
    tick(4);
    locked = 2'b01;
    tick();
    locked = 2'b11;
    tick();
    check("w_cnt5", state, 2'd1);
    tick();
    check("w_hold", state, 2'd0);
    check("w_loss", loss, 8'd3);
    wait_ready(lat);
    check("w_relat", lat, 14);

    for (int i = 1; i <= 300; i++) begin
      locked = 2'b00;
      tick(2);
      locked = 2'b11;
      tick(3);
      if (i == 251) check("sat_254", loss, 8'd254);
      if (i == 252) check("sat_255", loss, 8'd255);
    end
    check("sat_end", loss, 8'd255);
    check("sat_lost", lost, 1'b1);

    wait_ready(lat);
    rst_n = 1'b0;
    #2;
    check("async_dom", dom, 3'b000);
    check("async_state", state, 2'd0);
    check("async_lost", lost, 1'b0);
    check("async_loss", loss, 8'd0);

`ifdef RESET_SEQ_HOLD_TIMEOUT_EN
    locked = 2'b00;
    tick();
    rst_n = 1'b1;
    tick(31);
    check("to_e31", timeout, 1'b0);
    tick();
    check("to_e32", timeout, 1'b1);
    locked = 2'b11;
    wait_ready(lat);
    check("to_ready", ready, 1'b1);
    check("to_clear", timeout, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
